// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state
// encoding, default sizes and flat-bus slice arithmetic.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Low bit index of element idx in a flat bus of width-bit elements.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, set wins on a same-cycle
// collision. Register 0 is never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NWR   = 2,
    parameter int unsigned NRD   = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_en_i,
    input  logic [NWR*AW-1:0] wr_addr_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_rd_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD-1:0]    rd_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy vector: clears from every write port first, then the issue set on top.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            busy_d[wr_addr_i[slice_lo(p, AW) +: AW]] =
                busy_d[wr_addr_i[slice_lo(p, AW) +: AW]] & ~wr_en_i[p];
        end
        busy_d[iss_rd_i] = busy_d[iss_rd_i] | iss_en_i;
        busy_d[0]        = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_busy_rd
        assign rd_busy_o[r] = busy_q[rd_addr_i[slice_lo(r, AW) +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write priority, optional write-to-read
// bypass and a post-reset clear sequencer so the storage array needs no reset.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NWR    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NRD*$clog2(NREGS)-1:0]       rd_addr_i,
    output logic [NRD*XLEN-1:0]                rd_data_o,
    output logic [NRD-1:0]                     rd_busy_o,
    input  logic [NWR-1:0]                     wr_en_i,
    input  logic [NWR*$clog2(NREGS)-1:0]       wr_addr_i,
    input  logic [NWR*XLEN-1:0]                wr_data_i,
    input  logic                               iss_en_i,
    input  logic [$clog2(NREGS)-1:0]           iss_rd_i,
    output logic                               ready_o
);

    localparam int unsigned AW = $clog2(NREGS);

    rf_state_e        state_q;
    rf_state_e        state_d;
    logic [AW-1:0]    clr_ptr_q;
    logic [AW-1:0]    clr_ptr_d;
    logic             run_s;
    logic [NRD-1:0]   sb_busy_s;
    logic [XLEN-1:0]  mem_q [NREGS];

    assign run_s   = (state_q == RF_RUN);
    assign ready_o = run_s;

    // Clear sequencer state register; entry 0 is skipped since it always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RF_CLEAR;
            clr_ptr_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Clear sequencer next state.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            RF_CLEAR: begin
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == AW'(NREGS - 1)) begin
                    state_d = RF_RUN;
                end else begin
                    state_d = RF_CLEAR;
                end
            end
            RF_RUN:  state_d = RF_RUN;
            default: state_d = RF_CLEAR;
        endcase
    end

    // Storage array: later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk) begin
        if (state_q == RF_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[slice_lo(p, AW) +: AW] != '0)) begin
                    mem_q[wr_addr_i[slice_lo(p, AW) +: AW]] <= wr_data_i[slice_lo(p, XLEN) +: XLEN];
                end
            end
        end
    end

    for (genvar r = 0; r < NRD; r++) begin : g_rd
        logic [AW-1:0]   ra_s;
        logic [XLEN-1:0] rd_val_s;

        assign ra_s = rd_addr_i[slice_lo(r, AW) +: AW];

        // Read mux with optional bypass; scanning ports upward gives the highest index priority.
        always_comb begin
            rd_val_s = '0;
            if (run_s && (ra_s != '0)) begin
                rd_val_s = mem_q[ra_s];
                for (int p = 0; p < NWR; p++) begin
                    if (BYPASS && wr_en_i[p] && (wr_addr_i[slice_lo(p, AW) +: AW] == ra_s)) begin
                        rd_val_s = wr_data_i[slice_lo(p, XLEN) +: XLEN];
                    end else begin
                        rd_val_s = rd_val_s;
                    end
                end
            end else begin
                rd_val_s = '0;
            end
        end

        assign rd_data_o[slice_lo(r, XLEN) +: XLEN] = rd_val_s;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en_i & {NWR{run_s}}),
        .wr_addr_i (wr_addr_i),
        .iss_en_i  (iss_en_i & run_s),
        .iss_rd_i  (iss_rd_i),
        .rd_addr_i (rd_addr_i),
        .rd_busy_o (sb_busy_s)
    );

    assign rd_busy_o = sb_busy_s & {NRD{run_s}};

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: two instances (bypass on/off) share stimulus; a vector table
// covers RUN-mode behaviour, hand sequences cover clear and mid-clear reset.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_rd;

    logic [63:0] rd_data_b1, rd_data_b0;
    logic [1:0]  rd_busy_b1, rd_busy_b0;
    logic        ready_b1, ready_b0;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b1),
        .rd_busy_o(rd_busy_b1), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_rd_i(iss_rd), .ready_o(ready_b1)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b0)) u_dut_b0 (
        .clk(clk), .rst_n(rst_n), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b0),
        .rd_busy_o(rd_busy_b0), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .iss_en_i(iss_en), .iss_rd_i(iss_rd), .ready_o(ready_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd0, rd1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iss;
        logic [4:0]  ird;
        logic [31:0] e1_0, e1_1, e0_0, e0_1;
        logic [1:0]  busy;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en   = 2'b00;
        wr_addr = 10'd0;
        wr_data = 64'd0;
        iss_en  = 1'b0;
        iss_rd  = 5'd0;
    endtask

    // Counts rising edges until ready; returns 99 if the bound expires.
    task automatic count_clear(output int edges, input int probe_at);
        edges = 99;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == probe_at) begin
                chk("clear_rd_data_b1", rd_data_b1[31:0], 32'd0);
                chk("clear_rd_data_b0", rd_data_b0[63:32], 32'd0);
                chk("clear_busy", {30'd0, rd_busy_b1 | rd_busy_b0}, 32'd0);
            end
            if (ready_b1 || ready_b0) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        int edges;

        vec[0]  = '{5'd5, 5'd6, 2'b11, 5'd5, 5'd5, 32'h11, 32'h22, 1'b0, 5'd0, 32'h22, 32'h0, 32'h0, 32'h0, 2'b00};
        vec[1]  = '{5'd5, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h22, 32'h22, 32'h22, 32'h22, 2'b00};
        vec[2]  = '{5'd7, 5'd5, 2'b01, 5'd7, 5'd0, 32'hDEAD, 32'h0, 1'b0, 5'd0, 32'hDEAD, 32'h22, 32'h0, 32'h22, 2'b00};
        vec[3]  = '{5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'hDEAD, 32'h0, 32'hDEAD, 32'h0, 2'b00};
        vec[4]  = '{5'd0, 5'd0, 2'b11, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00};
        vec[5]  = '{5'd0, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00};
        vec[6]  = '{5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01};
        vec[7]  = '{5'd3, 5'd3, 2'b10, 5'd0, 5'd3, 32'h0, 32'h33, 1'b0, 5'd0, 32'h33, 32'h33, 32'h0, 32'h0, 2'b11};
        vec[8]  = '{5'd3, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h33, 32'h33, 32'h33, 32'h33, 2'b00};
        vec[9]  = '{5'd3, 5'd5, 2'b01, 5'd3, 5'd0, 32'h44, 32'h0, 1'b1, 5'd3, 32'h44, 32'h22, 32'h33, 32'h22, 2'b00};
        vec[10] = '{5'd3, 5'd5, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h44, 32'h22, 32'h44, 32'h22, 2'b01};
        vec[11] = '{5'd8, 5'd9, 2'b11, 5'd8, 5'd9, 32'h88, 32'h99, 1'b0, 5'd0, 32'h88, 32'h99, 32'h0, 32'h0, 2'b00};
        vec[12] = '{5'd9, 5'd8, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h99, 32'h88, 32'h99, 32'h88, 2'b00};
        vec[13] = '{5'd9, 5'd3, 2'b01, 5'd9, 5'd9, 32'hA, 32'hB, 1'b0, 5'd0, 32'hA, 32'h44, 32'h99, 32'h44, 2'b10};
        vec[14] = '{5'd9, 5'd3, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'hA, 32'h44, 32'hA, 32'h44, 2'b10};

        // Reset with writes and an issue held active; nothing may land during CLEAR.
        rst_n   = 1'b0;
        rd_addr = {5'd2, 5'd1};
        wr_en   = 2'b11;
        wr_addr = {5'd2, 5'd1};
        wr_data = {32'hCAFE_0002, 32'hCAFE_0001};
        iss_en  = 1'b1;
        iss_rd  = 5'd5;
        #2;
        chk("reset_ready", {30'd0, ready_b1, ready_b0}, 32'd0);
        chk("reset_busy", {28'd0, rd_busy_b1, rd_busy_b0}, 32'd0);
        chk("reset_rd_data", rd_data_b1[31:0] | rd_data_b1[63:32] | rd_data_b0[31:0] | rd_data_b0[63:32], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_clear(edges, 5);
        chk("clear_length", edges, 32'd31);
        chk("ready_both", {31'd0, ready_b0}, 32'd1);
        idle_inputs();

        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            rd_addr = {5'(31 - r), 5'(r)};
            #1;
            chk("post_clear_b1", rd_data_b1[31:0] | rd_data_b1[63:32], 32'd0);
            chk("post_clear_b0", rd_data_b0[31:0] | rd_data_b0[63:32], 32'd0);
            chk("post_clear_busy", {28'd0, rd_busy_b1, rd_busy_b0}, 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            rd_addr = {vec[i].rd1, vec[i].rd0};
            wr_en   = vec[i].we;
            wr_addr = {vec[i].wa1, vec[i].wa0};
            wr_data = {vec[i].wd1, vec[i].wd0};
            iss_en  = vec[i].iss;
            iss_rd  = vec[i].ird;
            #1;
            chk($sformatf("v%0d_b1_p0", i), rd_data_b1[31:0], vec[i].e1_0);
            chk($sformatf("v%0d_b1_p1", i), rd_data_b1[63:32], vec[i].e1_1);
            chk($sformatf("v%0d_b0_p0", i), rd_data_b0[31:0], vec[i].e0_0);
            chk($sformatf("v%0d_b0_p1", i), rd_data_b0[63:32], vec[i].e0_1);
            chk($sformatf("v%0d_busy_b1", i), {30'd0, rd_busy_b1}, {30'd0, vec[i].busy});
            chk($sformatf("v%0d_busy_b0", i), {30'd0, rd_busy_b0}, {30'd0, vec[i].busy});
        end

        // Mid-clear reset: r3 is busy here; reset at clr_ptr = 10 must restart the full clear.
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_ready_drop", {30'd0, ready_b1, ready_b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("midclr_ready", {30'd0, ready_b1, ready_b0}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midclr_rst_ready", {30'd0, ready_b1, ready_b0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_clear(edges, 12);
        chk("reclear_length", edges, 32'd31);
        @(negedge clk);
        rd_addr = {5'd9, 5'd3};
        #1;
        chk("reclear_busy", {28'd0, rd_busy_b1, rd_busy_b0}, 32'd0);
        chk("reclear_r3", rd_data_b1[31:0] | rd_data_b0[31:0], 32'd0);
        chk("reclear_r9", rd_data_b1[63:32] | rd_data_b0[63:32], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with configurable read and write port counts, a write-to-read bypass, and a per-register busy scoreboard. After reset, a clear sequencer zeroes the storage array one entry per cycle, so the array carries no reset and can map to RAM/LUTRAM. It sits in the decode/writeback stage of the core: decode reads operands and marks destinations busy, and one or more writeback ports retire results.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of 2, ≥ 4; AW = $clog2(NREGS)
- NRD, 2, number of read ports, ≥ 1
- NWR, 2, number of write ports, ≥ 1
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return array contents only

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  scoreboard busy bit of each read address
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_en  in  1  mark iss_rd busy
- iss_rd  in  AW  destination register being issued
- ready  out  1  clear sequence done; register file usable

## Operation
- FSM states are CLEAR and RUN. Reset enters CLEAR with clr_ptr = 1.
- CLEAR:
  - Each cycle writes 0 to entry clr_ptr, then increments clr_ptr.
  - After the write to NREGS-1, the FSM goes to RUN.
  - In CLEAR, wr_en and iss_en are ignored, rd_data = 0, rd_busy = 0, ready = 0.
- RUN: ready = 1 and the FSM stays in RUN until the next reset.
- Register 0:
  - Reads always return 0 and rd_busy = 0.
  - Writes and issues to address 0 are dropped.
  - Entry 0 is never written.
- Write port conflicts: when several enabled ports target the same address, the highest-indexed port wins. Other addresses are written independently in the same cycle.
- Read, BYPASS = 1: if any enabled write port targets rd_addr (≠ 0), rd_data is that port's wr_data, using the highest index on conflict. Otherwise rd_data is the array value.
- Read, BYPASS = 0: rd_data is the array value only, so written data is visible the cycle after the write.
- Scoreboard:
  - busy[NREGS-1:1] resets asynchronously to 0.
  - iss_en sets busy[iss_rd].
  - Any enabled write to address a clears busy[a].
  - If an issue and a write hit the same address in the same cycle, the set wins, because the new producer is outstanding.
  - rd_busy reflects the registered busy bits and is not bypassed.
- A reset at any time, including mid-CLEAR, returns the FSM to CLEAR with clr_ptr = 1, clears busy, and deasserts ready immediately.

## Timing
- Reset values: ready = 0, rd_busy = 0, rd_data = 0, state = CLEAR.
- ready rises at the first rising edge after NREGS-1 clear cycles, counted from the first clk edge after rst_n deasserts. With NREGS = 32, ready = 1 after the 31st edge.
- Reads are combinational: zero-cycle latency from rd_addr, and from wr_* when BYPASS = 1.
- Writes take effect at the rising edge. With BYPASS = 0, data is readable in the next cycle.
- Busy set/clear is visible on rd_busy in the cycle after the edge.
- There is no backpressure. Callers gate on ready.

## Structure
- regfile_pkg holds:
  - the state enum (RF_CLEAR, RF_RUN);
  - the default parameter constants XLEN_DEF, NREGS_DEF;
  - the flat-slice helper functions.
- The natural sub-module is regfile_scoreboard: busy bits with set/clear and priority, parametrised by NREGS, NWR, NRD.
- The storage array, the write-priority mux, the bypass mux and the clear FSM stay in regfile_mp.

## Test plan
- Clear sequence: reset with NREGS = 32, hold wr_en = all ones → ready stays 0 for 31 cycles and then goes to 1; every register reads 0; no write lands during CLEAR.
- Write conflict: in RUN, port 0 writes 0x11 to r5 and port 1 writes 0x22 to r5 in the same cycle → r5 reads 0x22 in the next cycle.
- Bypass:
  - BYPASS = 1: write 0xDEAD to r7 while reading r7 → rd_data = 0xDEAD in the same cycle.
  - BYPASS = 0: same stimulus → rd_data = old value in that cycle, 0xDEAD in the next cycle.
- Register 0: write 0xFFFF_FFFF to r0 and issue r0 → r0 reads 0 and rd_busy = 0.
- Scoreboard:
  - Issue r3 → rd_busy = 1 in the next cycle.
  - Write r3 → rd_busy = 0 in the next cycle.
  - Issue r3 and write r3 in the same cycle → rd_busy = 1.
- Mid-clear reset: assert rst_n = 0 at clr_ptr = 10 → ready stays 0, busy is cleared, and after release the full 31-cycle clear runs again.
